// File: rtl/register_bank_writer.sv
// rtl/register_bank_writer.sv - write side of the 64 x 16-bit configuration register bank
// Optional write lock on the low registers: define REG_WRITE_LOCK_EN.
module register_bank_writer #(
    parameter int                NUM_REGS  = 64,
    parameter int                DATA_W    = 16,
    parameter int                IDX_W     = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
`ifdef REG_WRITE_LOCK_EN
    ,
    parameter int                LOCK_LIMIT = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              burst_start,
    input  logic [IDX_W-1:0]  burst_index,
    input  logic [IDX_W:0]    burst_len,
    output logic              burst_busy,
    output logic              burst_done,
    output logic              wr_err,
`ifdef REG_WRITE_LOCK_EN
    input  logic              lock,
`endif
    output logic [DATA_W-1:0] regs [NUM_REGS]
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];

    logic               accept;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_tgt;
    logic               drop;

    // State register: every flop of the block, reset has priority over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next state: FSM transitions, burst pointer/count and the single register write
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_tgt  = '0;
        drop    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end

        accept = wr_valid && wr_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_tgt = wr_index;
                end
                // A same-cycle single write and burst request both take effect
                if (burst_start) begin
                    if (burst_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = burst_index;
                        cnt_d   = burst_len;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_tgt = ptr_q;
                    // Pointer wraps naturally at the power-of-two bank size
                    ptr_d  = ptr_q + IDX_W'(1);
                    cnt_d  = cnt_q - (IDX_W+1)'(1);
                    if (cnt_q == (IDX_W+1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef REG_WRITE_LOCK_EN
        // Locked writes still handshake and advance the burst, but never land
        drop = lock && (int'(wr_tgt) < LOCK_LIMIT);
`endif

        if (wr_en) begin
            if (drop) begin
                err_d = 1'b1;
            end else begin
                regs_d[wr_tgt] = wr_data;
            end
        end
    end

    // Outputs: handshake and status depend on registered state only
    always_comb begin
        wr_ready   = (state_q != ST_DONE);
        burst_busy = (state_q == ST_BURST);
        burst_done = (state_q == ST_DONE);
        wr_err     = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_register_bank_writer.sv
// tb/tb_register_bank_writer.sv - scoreboard bench for register_bank_writer
module tb_register_bank_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_index;
    logic [15:0] wr_data;
    logic        burst_start;
    logic [5:0]  burst_index;
    logic [6:0]  burst_len;
    logic        burst_busy;
    logic        burst_done;
    logic        wr_err;
    logic        lock;
    logic [15:0] regs [64];

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [15:0] exp_regs [64];
    int          n_cmp = 0;
    int          n_bad = 0;

    register_bank_writer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .burst_start (burst_start),
        .burst_index (burst_index),
        .burst_len   (burst_len),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done),
        .wr_err      (wr_err),
`ifdef REG_WRITE_LOCK_EN
        .lock        (lock),
`endif
        .regs        (regs)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one accepted word; the expected landing is queued and modelled
    task automatic push_write(input logic [5:0] tgt, input logic [5:0] drv_idx,
                              input logic [15:0] data);
        wr_valid = 1'b1;
        wr_index = drv_idx;
        wr_data  = data;
        sb.push_back('{idx: tgt, data: data});
        exp_regs[tgt] = data;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) exp_regs[i] = 16'h0000;
        step();
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL reset_regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
        n_cmp++;
        if ({wr_ready, burst_busy, burst_done, wr_err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_status got rdy/busy/done/err=%b want 1000",
                     {wr_ready, burst_busy, burst_done, wr_err});
        end
    endtask

    task automatic test_single();
        push_write(6'd37, 6'd37, 16'hBEEF);
        e = sb.pop_front();
        n_cmp++;
        if (regs[e.idx] !== e.data) begin
            n_bad++;
            $display("FAIL single_word regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
        end
        n_cmp++;
        if (wr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_err got %b want 0", wr_err);
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL single_others regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] words [4];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        burst_start = 1'b1;
        burst_index = 6'd62;
        burst_len   = 7'd4;
        step();
        burst_start = 1'b0;
        n_cmp++;
        if (burst_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_busy_start got %b want 1", burst_busy);
        end
        for (int k = 0; k < 4; k++) begin
            push_write(6'(62 + k), 6'd5, words[k]);
            e = sb.pop_front();
            n_cmp++;
            if (regs[e.idx] !== e.data) begin
                n_bad++;
                $display("FAIL wrap_word regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
            end
            if (k < 3) begin
                step();
                n_cmp++;
                if ({wr_ready, burst_busy, burst_done} !== 3'b110) begin
                    n_bad++;
                    $display("FAIL wrap_gap k=%0d got rdy/busy/done=%b want 110",
                             k, {wr_ready, burst_busy, burst_done});
                end
            end
        end
        n_cmp++;
        if ({wr_ready, burst_busy, burst_done} !== 3'b001) begin
            n_bad++;
            $display("FAIL wrap_done got rdy/busy/done=%b want 001",
                     {wr_ready, burst_busy, burst_done});
        end
        step();
        n_cmp++;
        if ({wr_ready, burst_busy, burst_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL wrap_after_done got rdy/busy/done=%b want 100",
                     {wr_ready, burst_busy, burst_done});
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL wrap_array regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        burst_start = 1'b1;
        burst_index = 6'd20;
        burst_len   = 7'd0;
        step();
        burst_start = 1'b0;
        n_cmp++;
        if ({wr_err, burst_busy, wr_ready} !== 3'b101) begin
            n_bad++;
            $display("FAIL zero_len_err got err/busy/rdy=%b want 101",
                     {wr_err, burst_busy, wr_ready});
        end
        step();
        n_cmp++;
        if ({wr_err, burst_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_len_clear got err/busy=%b want 00", {wr_err, burst_busy});
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL zero_len_array regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        burst_start = 1'b1;
        burst_index = 6'd10;
        burst_len   = 7'd8;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_write(6'(10 + k), 6'd0, 16'hC000 + 16'(k));
            e = sb.pop_front();
            n_cmp++;
            if (regs[e.idx] !== e.data) begin
                n_bad++;
                $display("FAIL mid_word regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) exp_regs[i] = 16'h0000;
        n_cmp++;
        if ({wr_ready, burst_busy, burst_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL mid_reset_status got rdy/busy/done=%b want 100",
                     {wr_ready, burst_busy, burst_done});
        end
        step();
        n_cmp++;
        if ({burst_busy, burst_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_no_done got busy/done=%b want 00", {burst_busy, burst_done});
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL mid_array regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
        push_write(6'd5, 6'd5, 16'h00A5);
        e = sb.pop_front();
        n_cmp++;
        if (regs[e.idx] !== e.data) begin
            n_bad++;
            $display("FAIL mid_followup regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
        end
    endtask

    task automatic test_back_to_back();
        // Single write and burst request in the same IDLE cycle
        burst_start = 1'b1;
        burst_index = 6'd40;
        burst_len   = 7'd2;
        push_write(6'd20, 6'd20, 16'h1234);
        burst_start = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (regs[e.idx] !== e.data || burst_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL combo_single regs[%0d] got %h want %h busy %b want 1",
                     e.idx, regs[e.idx], e.data, burst_busy);
        end
        push_write(6'd40, 6'd20, 16'hAAA0);
        push_write(6'd41, 6'd20, 16'hAAA1);
        n_cmp++;
        if (burst_done !== 1'b1) begin
            n_bad++;
            $display("FAIL combo_done got %b want 1", burst_done);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (regs[e.idx] !== e.data) begin
                n_bad++;
                $display("FAIL combo_burst regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
            end
        end
        step();
        // Full-length burst from a mid base wraps through every register once
        burst_start = 1'b1;
        burst_index = 6'd30;
        burst_len   = 7'd64;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            push_write(6'(30 + k), 6'($urandom_range(0, 63)), 16'($urandom));
            e = sb.pop_front();
            n_cmp++;
            if (regs[e.idx] !== e.data) begin
                n_bad++;
                $display("FAIL full_word regs[%0d] got %h want %h", e.idx, regs[e.idx], e.data);
            end
        end
        n_cmp++;
        if ({wr_ready, burst_busy, burst_done} !== 3'b001) begin
            n_bad++;
            $display("FAIL full_done got rdy/busy/done=%b want 001",
                     {wr_ready, burst_busy, burst_done});
        end
        step();
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (regs[i] !== exp_regs[i]) begin
                n_bad++;
                $display("FAIL full_array regs[%0d] got %h want %h", i, regs[i], exp_regs[i]);
            end
        end
    endtask

`ifdef REG_WRITE_LOCK_EN
    task automatic test_lock();
        lock     = 1'b1;
        wr_valid = 1'b1;
        wr_index = 6'd3;
        wr_data  = 16'h7777;
        step();
        wr_valid = 1'b0;
        n_cmp++;
        if (regs[3] !== exp_regs[3] || wr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_drop regs[3] got %h want %h err %b want 1",
                     regs[3], exp_regs[3], wr_err);
        end
        push_write(6'd8, 6'd8, 16'h8888);
        e = sb.pop_front();
        n_cmp++;
        if (regs[e.idx] !== e.data || wr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_pass regs[%0d] got %h want %h err %b want 0",
                     e.idx, regs[e.idx], e.data, wr_err);
        end
        lock = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        wr_valid    = 1'b0;
        wr_index    = '0;
        wr_data     = '0;
        burst_start = 1'b0;
        burst_index = '0;
        burst_len   = '0;
        lock        = 1'b0;
        test_reset();
        test_single();
        test_burst_wrap();
        test_zero_len();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef REG_WRITE_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_bank_writer.md
Name: register_bank_writer

Overview:
- Write side of the 64 x 16-bit configuration register bank.
- Owns the storage and drives the full register array to the combinational read-select logic.
- Accepts host writes over a valid/ready port in two modes:
  - single-word mode: explicit index per write.
  - burst mode: auto-increment from a base index over a programmed length.
- Sits between the host/config interface and all register consumers.

Parameters:
- NUM_REGS, 64, number of registers; fixed power of two; IDX_W = log2(NUM_REGS).
- DATA_W, 16, register width in bits.
- IDX_W, 6, index width.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_valid  input  1  write word present.
- wr_ready  output  1  block can accept a write this cycle.
- wr_index  input  IDX_W  target index; single mode only, ignored in burst.
- wr_data  input  DATA_W  write data.
- burst_start  input  1  request burst; sampled only in IDLE.
- burst_index  input  IDX_W  burst base index, latched on burst_start.
- burst_len  input  IDX_W+1  word count, 0..64; latched on burst_start.
- burst_busy  output  1  high in BURST state.
- burst_done  output  1  one-cycle pulse after last burst word written.
- wr_err  output  1  one-cycle error pulse.
- regs  output  DATA_W x NUM_REGS  unpacked array of current register contents.

Behaviour:
- Reset: synchronous; takes priority over all inputs.
  - Every regs[i] = RESET_VAL; state = IDLE; ptr = 0; cnt = 0.
  - burst_busy = 0; burst_done = 0; wr_err = 0; wr_ready = 1 from the first cycle after reset.
  - Reset mid-burst aborts the burst: no burst_done pulse, partially written registers return to RESET_VAL.
- Handshake:
  - A write is accepted on an edge where wr_valid && wr_ready.
  - wr_data lands in the target register at that edge and is visible on regs the cycle after (one-cycle latency).
  - No combinational path from any input to wr_ready; wr_ready is a function of state only.
- FSM states:
  - IDLE: wr_ready = 1.
    - Accepted write goes to regs[wr_index].
    - burst_start with burst_len 1..64: latch ptr = burst_index and cnt = burst_len, go to BURST.
    - burst_start with burst_len = 0: stay IDLE, pulse wr_err next cycle.
    - burst_start and an accepted single write in the same cycle: both take effect. The single write lands at wr_index; the burst begins next cycle.
  - BURST: wr_ready = 1; burst_busy = 1; burst_start is ignored.
    - Each accepted write goes to regs[ptr].
    - ptr = ptr + 1 modulo NUM_REGS, so 63 wraps to 0.
    - cnt = cnt - 1.
    - On the accept where cnt == 1, go to DONE.
    - Idle cycles (wr_valid low) hold ptr and cnt; there is no timeout.
  - DONE: one cycle.
    - wr_ready = 0; burst_done = 1; burst_busy = 0.
    - Next state is IDLE unconditionally.
- A 64-word burst from any base writes every register exactly once, wrapping through 63 -> 0.
- Writes never alter registers other than the target.

Optional Feature:
- Macro: REG_WRITE_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit) and parameter LOCK_LIMIT (default 8).
  - While lock = 1, accepted writes whose target index (wr_index or ptr) < LOCK_LIMIT are dropped.
  - A dropped write still completes the handshake, still advances ptr/cnt in burst, and pulses wr_err the next cycle.
- When undefined:
  - No lock port; all accepted writes land.
  - wr_err pulses only for a zero-length burst_start.

Test Plan:
- Reset then idle -> all 64 regs = 16'h0000, wr_ready = 1, burst_busy = 0, burst_done = 0, wr_err = 0.
- Single write index 6'd37, data 16'hBEEF -> regs[37] = 16'hBEEF one cycle after the accept; all other regs unchanged.
- burst_start base 62, len 4; data 16'h1111..16'h4444 with wr_valid gapped every other cycle:
  - regs[62] = 16'h1111, regs[63] = 16'h2222, regs[0] = 16'h3333, regs[1] = 16'h4444.
  - burst_done pulses once; wr_ready = 0 for that one cycle.
- burst_start with len 0 -> state stays IDLE, wr_err pulses 1 cycle, no register changes.
- Burst base 10, len 8; rst asserted after 3 words:
  - All regs = RESET_VAL; state IDLE; no burst_done pulse.
  - A following single write to index 5 (data 16'h00A5) lands normally.
- REG_WRITE_LOCK_EN defined, lock = 1, single write index 3 then index 8:
  - regs[3] unchanged and wr_err pulses.
  - regs[8] updated and no wr_err.
